rv64g_reg_scoreboard: RTL and testbench

// - Parametrised register-hazard scoreboard for the instruction launcher; tracks in-flight

---
 rtl/rv64g_reg_scoreboard.sv | 111 +++++++++++
 tb/tb_rv64g_reg_scoreboard.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv64g_reg_scoreboard.sv
// Register-hazard scoreboard for the instruction launcher: per-register locks over the
// unified GPR+FPR space, in-flight count, blocking-instruction gate and sticky protocol error.
module rv64g_reg_scoreboard #(
    parameter int NUM_REGS        = 64,
    parameter int NUM_OUTSTANDING = 7,
    parameter int NUM_RET         = 2,
    parameter bit ZERO_REG_EN     = 1'b1,
    localparam int AW = $clog2(NUM_REGS),
    localparam int CW = $clog2(NUM_OUTSTANDING + 1)
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    input  logic                        flush_i,
    input  logic                        instr_valid_i,
    output logic                        instr_ready_o,
    input  logic [AW-1:0]               instr_rd_i,
    input  logic [NUM_REGS-1:0]         instr_reg_req_i,
    input  logic                        instr_blocking_i,
    input  logic [NUM_RET-1:0]          ret_valid_i,
    input  logic [NUM_RET-1:0][AW-1:0]  ret_rd_i,
    output logic [NUM_REGS-1:0]         locked_o,
    output logic [CW-1:0]               outstanding_o,
    output logic                        empty_o,
    output logic                        err_o
);

    logic [NUM_REGS-1:0] lock_q, lock_nxt, set_mask, clr_mask;
    logic [CW-1:0]       cnt_q, cnt_nxt;
    logic                blk_q, blk_nxt;
    logic                err_q, err_nxt;
    logic                issue;
    int                  n_ret;

    function automatic logic is_none(input logic [AW-1:0] rd);
        return ZERO_REG_EN && (rd == '0);
    endfunction

    // Count update saturating at zero; underflow is reported separately.
    function automatic logic [CW-1:0] sat_count(input int cur, input int inc, input int dec);
        if (cur + inc < dec)
            return '0;
        return CW'(cur + inc - dec);
    endfunction

    assign instr_ready_o = !arst_i && !flush_i && !blk_q
                         && ((lock_q & instr_reg_req_i) == '0)
                         && (cnt_q < CW'(NUM_OUTSTANDING))
                         && (!instr_blocking_i || (cnt_q == '0));
    assign issue         = instr_valid_i && instr_ready_o;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        n_ret    = 0;
        err_nxt  = err_q;
        if (issue && !is_none(instr_rd_i))
            set_mask[instr_rd_i] = 1'b1;
        for (int p = 0; p < NUM_RET; p++) begin
            if (ret_valid_i[p]) begin
                n_ret = n_ret + 1;
                if (!is_none(ret_rd_i[p])) begin
                    clr_mask[ret_rd_i[p]] = 1'b1;
                    if (!lock_q[ret_rd_i[p]])
                        err_nxt = 1'b1;
                end
            end
        end
        for (int p = 0; p < NUM_RET; p++) begin
            for (int q = p + 1; q < NUM_RET; q++) begin
                if (ret_valid_i[p] && ret_valid_i[q] && (ret_rd_i[p] == ret_rd_i[q])
                    && !is_none(ret_rd_i[p]))
                    err_nxt = 1'b1;
            end
        end
        if (int'(cnt_q) + int'(issue) < n_ret)
            err_nxt = 1'b1;
        cnt_nxt  = sat_count(int'(cnt_q), int'(issue), n_ret);
        // A lock set by this cycle's issue survives a same-cycle retire of that register.
        lock_nxt = (lock_q & ~clr_mask) | set_mask;
        if (cnt_nxt == '0)
            blk_nxt = 1'b0;
        else if (issue && instr_blocking_i)
            blk_nxt = 1'b1;
        else
            blk_nxt = blk_q;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lock_q <= '0;
            cnt_q  <= '0;
            blk_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (flush_i) begin
            lock_q <= '0;
            cnt_q  <= '0;
            blk_q  <= 1'b0;
        end else begin
            lock_q <= lock_nxt;
            cnt_q  <= cnt_nxt;
            blk_q  <= blk_nxt;
            err_q  <= err_nxt;
        end
    end

    assign locked_o      = lock_q;
    assign outstanding_o = cnt_q;
    assign empty_o       = (cnt_q == '0);
    assign err_o         = err_q;

endmodule

// File: tb/tb_rv64g_reg_scoreboard.sv
// Directed bench for rv64g_reg_scoreboard: per-cycle comparison against an array/integer
// model of the scoreboard rules, plus hand-computed literal checks along the scenario.
module tb_rv64g_reg_scoreboard;

    logic             clk = 1'b0;
    logic             arst = 1'b0;
    logic             flush;
    logic             valid;
    logic             ready;
    logic [5:0]       rd;
    logic [63:0]      req;
    logic             blocking;
    logic [1:0]       ret_valid;
    logic [1:0][5:0]  ret_rd;
    logic [63:0]      locked;
    logic [2:0]       outstanding;
    logic             empty;
    logic             err;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    bit m_lock [64];
    int m_cnt = 0;
    bit m_blk = 1'b0;
    bit m_err = 1'b0;

    rv64g_reg_scoreboard dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .flush_i          (flush),
        .instr_valid_i    (valid),
        .instr_ready_o    (ready),
        .instr_rd_i       (rd),
        .instr_reg_req_i  (req),
        .instr_blocking_i (blocking),
        .ret_valid_i      (ret_valid),
        .ret_rd_i         (ret_rd),
        .locked_o         (locked),
        .outstanding_o    (outstanding),
        .empty_o          (empty),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_vec();
        logic [63:0] v = '0;
        for (int r = 0; r < 64; r++) v[r] = m_lock[r];
        return v;
    endfunction

    function automatic bit m_ready();
        bit conflict = 1'b0;
        for (int r = 0; r < 64; r++)
            if (m_lock[r] && req[r]) conflict = 1'b1;
        return !arst && !flush && !m_blk && !conflict && (m_cnt < 7)
               && (!blocking || m_cnt == 0);
    endfunction

    // Model: state changes as the scoreboard rules describe, evaluated on each clock edge.
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int r = 0; r < 64; r++) m_lock[r] = 1'b0;
            m_cnt = 0; m_blk = 1'b0; m_err = 1'b0;
        end else if (flush) begin
            for (int r = 0; r < 64; r++) m_lock[r] = 1'b0;
            m_cnt = 0; m_blk = 1'b0;
        end else begin
            automatic bit iss = valid && m_ready();
            automatic int n = 0;
            for (int p = 0; p < 2; p++) begin
                if (ret_valid[p]) begin
                    n++;
                    if (ret_rd[p] != 0 && !m_lock[ret_rd[p]]) m_err = 1'b1;
                end
            end
            if (ret_valid == 2'b11 && ret_rd[0] == ret_rd[1] && ret_rd[0] != 0) m_err = 1'b1;
            for (int p = 0; p < 2; p++)
                if (ret_valid[p] && ret_rd[p] != 0) m_lock[ret_rd[p]] = 1'b0;
            if (iss && rd != 0) m_lock[rd] = 1'b1;
            m_cnt = m_cnt + int'(iss) - n;
            if (m_cnt < 0) begin
                m_cnt = 0;
                m_err = 1'b1;
            end
            if (m_cnt == 0) m_blk = 1'b0;
            else if (iss && blocking) m_blk = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_locked", locked, m_vec());
            chk("cyc_outstanding", 64'(outstanding), 64'(m_cnt));
            chk("cyc_empty", 64'(empty), 64'(m_cnt == 0));
            chk("cyc_err", 64'(err), 64'(m_err));
            chk("cyc_ready", 64'(ready), 64'(m_ready()));
        end
    end

    task automatic idle();
        valid = 1'b0; rd = '0; req = '0; blocking = 1'b0;
        ret_valid = '0; ret_rd = '0; flush = 1'b0;
    endtask

    task automatic next();
        @(posedge clk); #1; idle();
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic iss(input int r);
        valid = 1'b1; rd = 6'(r); req = 64'(1) << r;
    endtask

    task automatic ret(input int p, input int r);
        ret_valid[p] = 1'b1; ret_rd[p] = 6'(r);
    endtask

    initial begin
        idle();
        #1 arst = 1'b1;
        chk_en = 1'b1;
        req = 64'(1) << 5;
        mid();
        chk("rst_locked", locked, 64'h0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        @(posedge clk); #1; arst = 1'b0; idle();

        iss(5); mid(); chk("first_ready", 64'(ready), 64'd1);
        next(); mid();
        chk("first_lock5", 64'(locked[5]), 64'd1);
        chk("first_out", 64'(outstanding), 64'd1);
        chk("first_empty", 64'(empty), 64'd0);

        req = 64'(1) << 5; mid(); chk("raw_ready", 64'(ready), 64'd0);
        ret(0, 5); next(); req = 64'(1) << 5; mid();
        chk("raw_rel_ready", 64'(ready), 64'd1);
        chk("raw_rel_locked", locked, 64'h0);

        for (int i = 1; i <= 7; i++) begin iss(i); next(); end
        req = 64'(1) << 20; mid();
        chk("fill_out", 64'(outstanding), 64'd7);
        chk("fill_ready", 64'(ready), 64'd0);
        ret(0, 1); ret(1, 2); next(); req = 64'(1) << 20; mid();
        chk("fill_ret_out", 64'(outstanding), 64'd5);
        chk("fill_ret_ready", 64'(ready), 64'd1);
        ret(0, 3); ret(1, 4); next();
        ret(0, 5); ret(1, 6); next();
        ret(0, 7); next(); mid();
        chk("drain_out", 64'(outstanding), 64'd0);

        iss(10); next(); iss(11); next();
        iss(12); blocking = 1'b1; mid();
        chk("blk_wait_ready", 64'(ready), 64'd0);
        ret(0, 10); ret(1, 11); next();
        iss(12); blocking = 1'b1; mid();
        chk("blk_go_ready", 64'(ready), 64'd1);
        next(); iss(13); mid();
        chk("blk_alone_ready", 64'(ready), 64'd0);
        chk("blk_alone_out", 64'(outstanding), 64'd1);
        valid = 1'b0; ret(0, 12); next(); req = 64'(1) << 13; mid();
        chk("blk_clear_ready", 64'(ready), 64'd1);

        iss(0); next(); mid();
        chk("x0_locked", locked, 64'h0);
        chk("x0_out", 64'(outstanding), 64'd1);
        iss(32); next(); mid();
        chk("f0_lock", 64'(locked[32]), 64'd1);
        iss(9); ret(0, 32); next(); mid();
        chk("cc_lock9", 64'(locked[9]), 64'd1);
        chk("cc_lock32", 64'(locked[32]), 64'd0);
        chk("cc_out", 64'(outstanding), 64'd2);
        ret(0, 0); ret(1, 9); next(); mid();
        chk("cc_drain_out", 64'(outstanding), 64'd0);

        iss(22); next();
        valid = 1'b1; rd = 6'd22; ret(0, 22); next(); mid();
        chk("setwins_lock", 64'(locked[22]), 64'd1);
        chk("setwins_out", 64'(outstanding), 64'd1);
        chk("setwins_err", 64'(err), 64'd0);
        ret(0, 22); next();

        iss(3); next();
        ret(0, 12); next(); mid();
        chk("unlk_err", 64'(err), 64'd1);
        ret(0, 0); next(); mid();
        chk("under_out", 64'(outstanding), 64'd0);
        chk("under_err", 64'(err), 64'd1);

        iss(14); next(); iss(15); next(); iss(16); next(); mid();
        chk("pre_flush_out", 64'(outstanding), 64'd3);
        iss(17); flush = 1'b1; mid();
        chk("flush_ready", 64'(ready), 64'd0);
        next(); mid();
        chk("flush_locked", locked, 64'h0);
        chk("flush_out", 64'(outstanding), 64'd0);
        chk("flush_err", 64'(err), 64'd1);

        iss(25); next(); iss(26); next();
        ret(0, 25); arst = 1'b1; #1;
        chk("arst_locked", locked, 64'h0);
        chk("arst_out", 64'(outstanding), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_err", 64'(err), 64'd0);
        chk("arst_ready", 64'(ready), 64'd0);
        next(); arst = 1'b0;

        iss(30); next(); iss(31); next();
        ret(0, 30); ret(1, 30); next(); mid();
        chk("dup_lock30", 64'(locked[30]), 64'd0);
        chk("dup_lock31", 64'(locked[31]), 64'd1);
        chk("dup_out", 64'(outstanding), 64'd0);
        chk("dup_err", 64'(err), 64'd1);
        next();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
